output_filter_slew: RTL and testbench

Multi-channel output filter, next generation of the PID output stage: takes per-channel signed deltas from the PID core, scales them by a multiplier and arithmetic right shift, accumulates them onto the previous output, then applies a per-channel slew-rate limit and min/max bounds. Adds per-channel enable/hold/slew modes, exact read-after-write on back-to-back same-channel samples, and a saturation flag. Sits between the PID pipeline and the DAC/output router; configured over the shared write bus.

---
 rtl/output_filter_slew.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_output_filter_slew.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_filter_slew.sv
// Multi-channel PID output stage: scales signed deltas, accumulates them per channel and
// limits the result by a per-channel slew rate and min/max bounds over a 5-stage pipeline.
module output_filter_slew #(
    parameter int W_CHAN         = 5,
    parameter int N_CHAN         = 8,
    parameter int W_DELTA        = 18,
    parameter int W_DOUT         = 16,
    parameter int W_MULT         = 10,
    parameter int W_RS           = 5,
    parameter int W_WR_ADDR      = 16,
    parameter int W_WR_CHAN      = 5,
    parameter int W_WR_DATA      = 48,
    parameter int OPT_MIN_ADDR   = 'h10,
    parameter int OPT_MAX_ADDR   = 'h11,
    parameter int OPT_INIT_ADDR  = 'h12,
    parameter int OPT_MULT_ADDR  = 'h13,
    parameter int OPT_RS_ADDR    = 'h14,
    parameter int OPT_SLEW_ADDR  = 'h15,
    parameter int OPT_MODE_ADDR  = 'h16,
    parameter int OPT_INJ_RQST   = 'h17,
    parameter int OPT_CLR_RQST   = 'h18
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 dv_in,
    input  logic [W_CHAN-1:0]    chan_in,
    input  logic [W_DELTA-1:0]   delta_in,
    input  logic                 wr_en,
    input  logic [W_WR_ADDR-1:0] wr_addr,
    input  logic [W_WR_CHAN-1:0] wr_chan,
    input  logic [W_WR_DATA-1:0] wr_data,
    output logic                 dv_out,
    output logic [W_CHAN-1:0]    chan_out,
    output logic [W_DOUT-1:0]    data_out,
    output logic                 sat_out
);

    localparam int W_IDX  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int W_P    = W_DELTA + W_MULT;
    localparam int W_SUM  = ((W_DOUT > W_P) ? W_DOUT : W_P) + 1;
    localparam int W_SLEW = W_DOUT - 1;
    localparam logic [W_DOUT-1:0] MIN_DEF  = {1'b1, {(W_DOUT-1){1'b0}}};
    localparam logic [W_DOUT-1:0] MAX_DEF  = {1'b0, {(W_DOUT-1){1'b1}}};
    localparam logic [W_MULT-1:0] MULT_DEF = W_MULT'(1);

    // Per-channel configuration and state
    logic [W_DOUT-1:0] min_q  [N_CHAN];
    logic [W_DOUT-1:0] min_d  [N_CHAN];
    logic [W_DOUT-1:0] max_q  [N_CHAN];
    logic [W_DOUT-1:0] max_d  [N_CHAN];
    logic [W_DOUT-1:0] init_q [N_CHAN];
    logic [W_DOUT-1:0] init_d [N_CHAN];
    logic [W_MULT-1:0] mult_q [N_CHAN];
    logic [W_MULT-1:0] mult_d [N_CHAN];
    logic [W_RS-1:0]   rs_q   [N_CHAN];
    logic [W_RS-1:0]   rs_d   [N_CHAN];
    logic [W_SLEW-1:0] slew_q [N_CHAN];
    logic [W_SLEW-1:0] slew_d [N_CHAN];
    logic [2:0]        mode_q [N_CHAN];
    logic [2:0]        mode_d [N_CHAN];
    logic [W_DOUT-1:0] prev_q [N_CHAN];
    logic [W_DOUT-1:0] prev_d [N_CHAN];
    logic [N_CHAN-1:0] inj_q, inj_d;

    logic a_min, a_max, a_init, a_mult, a_rs, a_slew, a_mode, a_inj, a_clr;
    logic [N_CHAN-1:0] wr_sel, clr_now, inj_pend;
    logic [W_IDX-1:0]  inj_sel, chan_idx, fetch_idx;
    logic              issue, chan_ok;
    logic              unused_bits;

    // Stage registers
    logic                    s1_v_q, s1_v_d;
    logic                    s1_inj_q, s1_hold_q, s1_slew_en_q;
    logic [W_IDX-1:0]        s1_idx_q;
    logic [W_DELTA-1:0]      s1_delta_q;
    logic [W_MULT-1:0]       s1_mult_q;
    logic [W_RS-1:0]         s1_rs_q;
    logic [W_SLEW-1:0]       s1_slew_q;
    logic [W_DOUT-1:0]       s1_min_q, s1_max_q, s1_init_q;

    logic                    s2_v_q, s2_v_d;
    logic                    s2_inj_q, s2_hold_q, s2_slew_en_q;
    logic [W_IDX-1:0]        s2_idx_q;
    logic signed [W_P-1:0]   s2_p_q, s2_p_d;
    logic [W_SLEW-1:0]       s2_slew_q;
    logic [W_DOUT-1:0]       s2_min_q, s2_max_q, s2_init_q;

    logic                    s3_v_q, s3_v_d;
    logic                    s3_inj_q, s3_hold_q;
    logic [W_IDX-1:0]        s3_idx_q;
    logic signed [W_P-1:0]   s3_step_q, s3_step_d;
    logic                    s3_ssat_q, s3_ssat_d;
    logic [W_DOUT-1:0]       s3_min_q, s3_max_q, s3_init_q;

    logic                    s4_v_q, s4_v_d;
    logic [W_IDX-1:0]        s4_idx_q;
    logic [W_DOUT-1:0]       s4_data_q, s4_data_d;
    logic                    s4_sat_q, s4_sat_d;

    logic                    dv_out_q, dv_out_d;
    logic [W_CHAN-1:0]       chan_out_q, chan_out_d;
    logic [W_DOUT-1:0]       data_out_q, data_out_d;
    logic                    sat_out_q, sat_out_d;

    logic                    kill1, kill2, kill3, kill4;
    logic                    wb_en;
    logic signed [W_P-1:0]   delta_ext, mult_ext, prod, slew_pos;
    logic signed [W_SUM-1:0] prev_ext, step_ext, sum, min_ext, max_ext;
    logic [W_DOUT-1:0]       prev_cur;

    assign a_min  = (wr_addr == W_WR_ADDR'(OPT_MIN_ADDR));
    assign a_max  = (wr_addr == W_WR_ADDR'(OPT_MAX_ADDR));
    assign a_init = (wr_addr == W_WR_ADDR'(OPT_INIT_ADDR));
    assign a_mult = (wr_addr == W_WR_ADDR'(OPT_MULT_ADDR));
    assign a_rs   = (wr_addr == W_WR_ADDR'(OPT_RS_ADDR));
    assign a_slew = (wr_addr == W_WR_ADDR'(OPT_SLEW_ADDR));
    assign a_mode = (wr_addr == W_WR_ADDR'(OPT_MODE_ADDR));
    assign a_inj  = (wr_addr == W_WR_ADDR'(OPT_INJ_RQST));
    assign a_clr  = (wr_addr == W_WR_ADDR'(OPT_CLR_RQST));
    assign unused_bits = ^wr_data[W_WR_DATA-1:W_DOUT];

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            wr_sel[i] = wr_en && (wr_chan == W_WR_CHAN'(i));
        end
        clr_now = wr_sel & {N_CHAN{a_clr && wr_data[0]}};
    end

    // A channel being cleared this cycle can neither issue nor keep its inject request.
    always_comb begin
        inj_pend = inj_q & ~clr_now;
        inj_sel  = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (inj_pend[i]) inj_sel = W_IDX'(i);
        end
        issue = !dv_in && (|inj_pend);
    end

    always_comb begin
        inj_d = inj_q;
        for (int i = 0; i < N_CHAN; i++) begin
            min_d[i]  = (wr_sel[i] && a_min)  ? wr_data[W_DOUT-1:0] : min_q[i];
            max_d[i]  = (wr_sel[i] && a_max)  ? wr_data[W_DOUT-1:0] : max_q[i];
            init_d[i] = (wr_sel[i] && a_init) ? wr_data[W_DOUT-1:0] : init_q[i];
            mult_d[i] = (wr_sel[i] && a_mult) ? wr_data[W_MULT-1:0] : mult_q[i];
            rs_d[i]   = (wr_sel[i] && a_rs)   ? wr_data[W_RS-1:0]   : rs_q[i];
            slew_d[i] = (wr_sel[i] && a_slew) ? wr_data[W_SLEW-1:0] : slew_q[i];
            mode_d[i] = (wr_sel[i] && a_mode) ? wr_data[2:0]        : mode_q[i];
            if (wr_sel[i] && a_inj) inj_d[i] = 1'b1;
            if (issue && (inj_sel == W_IDX'(i))) inj_d[i] = 1'b0;
            if (clr_now[i]) inj_d[i] = 1'b0;
        end
    end

    // S1 fetch: config arrays are read before this edge's writes land, so a same-cycle
    // write is seen only by the next sample.
    always_comb begin
        chan_idx  = chan_in[W_IDX-1:0];
        chan_ok   = (chan_in < W_CHAN'(N_CHAN));
        fetch_idx = dv_in ? chan_idx : inj_sel;
        s1_v_d    = issue || (dv_in && chan_ok && mode_q[chan_idx][0]);
    end

    assign kill1 = clr_now[s1_idx_q];
    assign kill2 = clr_now[s2_idx_q];
    assign kill3 = clr_now[s3_idx_q];
    assign kill4 = clr_now[s4_idx_q];

    // S2: scaled delta
    always_comb begin
        delta_ext = {{(W_P-W_DELTA){s1_delta_q[W_DELTA-1]}}, s1_delta_q};
        mult_ext  = {{(W_P-W_MULT){s1_mult_q[W_MULT-1]}}, s1_mult_q};
        prod      = delta_ext * mult_ext;
        s2_p_d    = prod >>> s1_rs_q;
        s2_v_d    = s1_v_q && !kill1;
    end

    // S3: since sum - prev is exactly p, the slew clamp acts on p directly and does not
    // depend on prev; this keeps the prev read (and its bypass) confined to S4.
    always_comb begin
        slew_pos  = {{(W_P-W_SLEW){1'b0}}, s2_slew_q};
        s3_step_d = s2_p_q;
        s3_ssat_d = 1'b0;
        if (s2_slew_en_q && (s2_p_q > slew_pos)) begin
            s3_step_d = slew_pos;
            s3_ssat_d = 1'b1;
        end else if (s2_slew_en_q && (s2_p_q < -slew_pos)) begin
            s3_step_d = -slew_pos;
            s3_ssat_d = 1'b1;
        end
        s3_v_d = s2_v_q && !kill2;
    end

    // S4: prev is written at the same edge that closes this stage, so the array always
    // holds the newest result and back-to-back samples never see stale data.
    always_comb begin
        prev_cur  = prev_q[s3_idx_q];
        prev_ext  = {{(W_SUM-W_DOUT){prev_cur[W_DOUT-1]}}, prev_cur};
        step_ext  = {{(W_SUM-W_P){s3_step_q[W_P-1]}}, s3_step_q};
        min_ext   = {{(W_SUM-W_DOUT){s3_min_q[W_DOUT-1]}}, s3_min_q};
        max_ext   = {{(W_SUM-W_DOUT){s3_max_q[W_DOUT-1]}}, s3_max_q};
        sum       = prev_ext + step_ext;
        s4_data_d = sum[W_DOUT-1:0];
        s4_sat_d  = s3_ssat_q;
        if (sum > max_ext) begin
            s4_data_d = s3_max_q;
            s4_sat_d  = 1'b1;
        end else if (sum < min_ext) begin
            s4_data_d = s3_min_q;
            s4_sat_d  = 1'b1;
        end
        wb_en = s3_v_q && !kill3 && !s3_hold_q;
        if (s3_inj_q) begin
            s4_data_d = s3_init_q;
            s4_sat_d  = 1'b0;
            wb_en     = s3_v_q && !kill3;
        end else if (s3_hold_q) begin
            s4_data_d = prev_cur;
            s4_sat_d  = 1'b0;
        end
        s4_v_d = s3_v_q && !kill3;
    end

    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            prev_d[i] = prev_q[i];
            if (wb_en && (s3_idx_q == W_IDX'(i))) prev_d[i] = s4_data_d;
            if (clr_now[i]) prev_d[i] = init_q[i];
        end
    end

    // S5: output register
    always_comb begin
        dv_out_d   = s4_v_q && !kill4;
        chan_out_d = dv_out_d ? W_CHAN'(s4_idx_q) : '0;
        data_out_d = dv_out_d ? s4_data_q : '0;
        sat_out_d  = dv_out_d && s4_sat_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                min_q[i]  <= MIN_DEF;
                max_q[i]  <= MAX_DEF;
                init_q[i] <= '0;
                mult_q[i] <= MULT_DEF;
                rs_q[i]   <= '0;
                slew_q[i] <= '1;
                mode_q[i] <= 3'b001;
                prev_q[i] <= '0;
            end
            inj_q      <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s3_v_q     <= 1'b0;
            s4_v_q     <= 1'b0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
            sat_out_q  <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            init_q     <= init_d;
            mult_q     <= mult_d;
            rs_q       <= rs_d;
            slew_q     <= slew_d;
            mode_q     <= mode_d;
            prev_q     <= prev_d;
            inj_q      <= inj_d;
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            s3_v_q     <= s3_v_d;
            s4_v_q     <= s4_v_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            data_out_q <= data_out_d;
            sat_out_q  <= sat_out_d;
        end
    end

    // Payload registers are qualified by the valid bits above and need no reset.
    always_ff @(posedge clk_in) begin
        s1_inj_q     <= !dv_in;
        s1_hold_q    <= mode_q[fetch_idx][1];
        s1_slew_en_q <= mode_q[fetch_idx][2];
        s1_idx_q     <= fetch_idx;
        s1_delta_q   <= delta_in;
        s1_mult_q    <= mult_q[fetch_idx];
        s1_rs_q      <= rs_q[fetch_idx];
        s1_slew_q    <= slew_q[fetch_idx];
        s1_min_q     <= min_q[fetch_idx];
        s1_max_q     <= max_q[fetch_idx];
        s1_init_q    <= init_q[fetch_idx];

        s2_inj_q     <= s1_inj_q;
        s2_hold_q    <= s1_hold_q;
        s2_slew_en_q <= s1_slew_en_q;
        s2_idx_q     <= s1_idx_q;
        s2_p_q       <= s2_p_d;
        s2_slew_q    <= s1_slew_q;
        s2_min_q     <= s1_min_q;
        s2_max_q     <= s1_max_q;
        s2_init_q    <= s1_init_q;

        s3_inj_q     <= s2_inj_q;
        s3_hold_q    <= s2_hold_q;
        s3_idx_q     <= s2_idx_q;
        s3_step_q    <= s3_step_d;
        s3_ssat_q    <= s3_ssat_d;
        s3_min_q     <= s2_min_q;
        s3_max_q     <= s2_max_q;
        s3_init_q    <= s2_init_q;

        s4_idx_q     <= s3_idx_q;
        s4_data_q    <= s4_data_d;
        s4_sat_q     <= s4_sat_d;
    end

    assign dv_out   = dv_out_q;
    assign chan_out = chan_out_q;
    assign data_out = data_out_q;
    assign sat_out  = sat_out_q;

endmodule

// File: tb/tb_output_filter_slew.sv
// Scoreboard bench for output_filter_slew: expected outputs (value and arrival cycle) are
// queued when stimulus is driven and checked by a monitor on the falling clock edge.
module tb_output_filter_slew;

    localparam logic [15:0] A_MIN  = 16'h10;
    localparam logic [15:0] A_MAX  = 16'h11;
    localparam logic [15:0] A_INIT = 16'h12;
    localparam logic [15:0] A_MULT = 16'h13;
    localparam logic [15:0] A_RS   = 16'h14;
    localparam logic [15:0] A_SLEW = 16'h15;
    localparam logic [15:0] A_MODE = 16'h16;
    localparam logic [15:0] A_INJ  = 16'h17;
    localparam logic [15:0] A_CLR  = 16'h18;

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        dv_in    = 1'b0;
    logic [4:0]  chan_in  = '0;
    logic [17:0] delta_in = '0;
    logic        wr_en    = 1'b0;
    logic [15:0] wr_addr  = '0;
    logic [4:0]  wr_chan  = '0;
    logic [47:0] wr_data  = '0;
    logic        dv_out;
    logic [4:0]  chan_out;
    logic [15:0] data_out;
    logic        sat_out;

    typedef struct {
        int chan;
        int data;
        bit sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   pc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    output_filter_slew dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .delta_in (delta_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .data_out (data_out),
        .sat_out  (sat_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) pc <= pc + 1;

    always @(negedge clk_in) begin
        if (rst_n_in && dv_out) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_out: got chan=%0d data=%0d sat=%0b at cyc %0d, required no output",
                         chan_out, $signed(data_out), sat_out, pc);
            end else begin
                e = sb.pop_front();
                if (int'(chan_out) !== e.chan || int'($signed(data_out)) !== e.data ||
                    sat_out !== e.sat || pc !== e.cyc) begin
                    tests_failed++;
                    $display("FAIL out_ch%0d: got chan=%0d data=%0d sat=%0b cyc=%0d, required chan=%0d data=%0d sat=%0b cyc=%0d",
                             e.chan, chan_out, $signed(data_out), sat_out, pc, e.chan, e.data, e.sat, e.cyc);
                end else begin
                    $display("[TB] out chan=%0d data=%0d sat=%0b cyc=%0d ok", e.chan, e.data, e.sat, pc);
                end
            end
        end
    end

    task automatic push_exp(input int ch, input int data, input bit sat, input int lat);
        exp_t x;
        x.chan = ch;
        x.data = data;
        x.sat  = sat;
        x.cyc  = pc + lat;
        sb.push_back(x);
    endtask

    task automatic send(input int ch, input int d);
        @(negedge clk_in);
        dv_in    = 1'b1;
        chan_in  = 5'(ch);
        delta_in = 18'(d);
        wr_en    = 1'b0;
    endtask

    task automatic send_exp(input int ch, input int d, input int data, input bit sat);
        send(ch, d);
        push_exp(ch, data, sat, 5);
    endtask

    task automatic cfg(input logic [15:0] addr, input int ch, input int val);
        @(negedge clk_in);
        dv_in   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_chan = 5'(ch);
        wr_data = 48'(val);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            dv_in = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        tests_run += 4;
        if (dv_out !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %0b, required 0", dv_out); end
        if (chan_out !== 5'd0) begin tests_failed++; $display("FAIL reset_chan: got %0d, required 0", chan_out); end
        if (data_out !== 16'd0) begin tests_failed++; $display("FAIL reset_data: got %0d, required 0", data_out); end
        if (sat_out !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %0b, required 0", sat_out); end
        rst_n_in = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_bypass;
        send_exp(0, 100, 100, 1'b0);
        send_exp(0, 100, 200, 1'b0);
        send_exp(0, 100, 300, 1'b0);
        idle(6);
    endtask

    task automatic test_mult_shift;
        cfg(A_MULT, 1, 3);
        cfg(A_RS, 1, 2);
        send_exp(1, -7, -6, 1'b0);
        idle(1);
        send_exp(1, 7, -1, 1'b0);
        cfg(A_MODE, 1, 0);
        send(1, 100);
        cfg(A_MODE, 1, 1);
        send_exp(1, 4, 2, 1'b0);
        idle(6);
    endtask

    task automatic test_slew;
        cfg(A_SLEW, 2, 10);
        cfg(A_MODE, 2, 5);
        send_exp(2, 50, 10, 1'b1);
        cfg(A_MAX, 2, 15);
        send_exp(2, 50, 15, 1'b1);
        send_exp(2, -3, 12, 1'b0);
        idle(6);
    endtask

    task automatic test_inject;
        cfg(A_INIT, 3, 1000);
        cfg(A_INJ, 3, 1);
        push_exp(3, 1000, 1'b0, 6);
        idle(7);
        send_exp(3, 5, 1005, 1'b0);
        cfg(A_MODE, 3, 3);
        send_exp(3, 5, 1005, 1'b0);
        idle(6);
    endtask

    task automatic test_clear;
        cfg(A_INIT, 4, 500);
        send(4, 10);
        send_exp(5, 7, 7, 1'b0);
        send(4, 10);
        send(4, 10);
        cfg(A_CLR, 4, 1);
        idle(6);
        send_exp(4, 1, 501, 1'b0);
        idle(6);
    endtask

    task automatic test_back_to_back;
        int seq_ch [6] = '{6, 7, 6, 6, 7, 7};
        int seq_d  [6] = '{30000, -20000, 30000, -5, -20000, 100};
        int model  [8] = '{default: 0};
        int s;
        bit sat;
        for (int i = 0; i < 6; i++) begin
            s   = model[seq_ch[i]] + seq_d[i];
            sat = 1'b0;
            if (s > 32767) begin s = 32767; sat = 1'b1; end
            if (s < -32768) begin s = -32768; sat = 1'b1; end
            model[seq_ch[i]] = s;
            send_exp(seq_ch[i], seq_d[i], s, sat);
        end
        idle(6);
    endtask

    task automatic test_async_reset;
        send(0, 1);
        repeat (5) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        dv_in    = 1'b0;
        #1;
        tests_run += 4;
        if (dv_out !== 1'b0) begin tests_failed++; $display("FAIL async_rst_dv: got %0b, required 0", dv_out); end
        if (chan_out !== 5'd0) begin tests_failed++; $display("FAIL async_rst_chan: got %0d, required 0", chan_out); end
        if (data_out !== 16'd0) begin tests_failed++; $display("FAIL async_rst_data: got %0d, required 0", data_out); end
        if (sat_out !== 1'b0) begin tests_failed++; $display("FAIL async_rst_sat: got %0b, required 0", sat_out); end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        dv_in    = 1'b1;
        chan_in  = 5'd0;
        delta_in = 18'd1;
        push_exp(0, 1, 1'b0, 5);
        send_exp(1, -7, -7, 1'b0);
        send_exp(3, 5, 5, 1'b0);
        send_exp(2, 50, 50, 1'b0);
        idle(8);
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_mult_shift;
        test_slew;
        test_inject;
        test_clear;
        test_back_to_back;
        test_async_reset;
        idle(8);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d outputs still outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
